// File: rtl/lcd_rect_fill.sv
// Rectangle fill sequencer: CASET/RASET/RAMWR command stream followed by N RGB565 pixels.
// Latency: first word registered the cycle after an accepted start; then one word per wr_done, no gaps.
// Backpressure: each word is held on data with en_write=1 until the writer returns wr_done.
//
// Ports:
//   sys_clk_50MHz, sys_rst      - rising-edge clock, async active-high reset
//   start, x0, x1, y0, y1, color - fill request (inclusive bounds, RGB565), latched on accept
//   wr_done                     - writer accepted the current word (ignored while en_write=0)
//   data[8:0], en_write         - {DC, byte} word to the writer and its valid
//   busy, done, err             - transfer active, completion pulse, rejected-request pulse
// Optional feature: define RECT_CLIP_EN to clip x1/y1 to the panel and reject off-panel x0/y0.
module lcd_rect_fill #(
  parameter int H_RES = 240,
  parameter int V_RES = 320
) (
  input  logic        sys_clk_50MHz,
  input  logic        sys_rst,
  input  logic        start,
  input  logic [8:0]  x0,
  input  logic [8:0]  x1,
  input  logic [8:0]  y0,
  input  logic [8:0]  y1,
  input  logic [15:0] color,
  input  logic        wr_done,
  output logic [8:0]  data,
  output logic        en_write,
  output logic        busy,
  output logic        done,
  output logic        err
);

  // The pixel counter is 17 bits; a panel larger than that could not be filled in one pass.
  if (H_RES * V_RES > 131072) begin : g_panel_too_large
    $error("lcd_rect_fill: H_RES*V_RES exceeds the 17-bit pixel counter");
  end

  localparam logic [8:0] CMD_CASET = 9'h02A;
  localparam logic [8:0] CMD_RASET = 9'h02B;
  localparam logic [8:0] CMD_RAMWR = 9'h02C;

  typedef enum logic [3:0] {
    IDLE, CASET, XPARAM, RASET, YPARAM, RAMWR, PIX_HI, PIX_LO, FINISH
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  pidx, pidx_nxt;
  logic [16:0] pix_cnt, pix_cnt_nxt;
  logic [16:0] n_last, n_last_d;
  logic [8:0]  x0_q, x1_q, y0_q, y1_q;
  logic [15:0] color_q;
  logic [8:0]  data_nxt;
  logic        en_nxt, busy_nxt, done_nxt, err_nxt;

  logic [8:0]  x1_eff, y1_eff;
  logic        off_panel, req_bad, accept, adv;
  logic [9:0]  w_pix, h_pix;
  logic [19:0] area;

  // Parameter bytes of CASET/RASET: start high, start low, end high, end low.
  function automatic logic [8:0] param_word(input logic [8:0] lo, input logic [8:0] hi,
                                            input logic [1:0] idx);
    case (idx)
      2'd0:    param_word = {1'b1, 7'd0, lo[8]};
      2'd1:    param_word = {1'b1, lo[7:0]};
      2'd2:    param_word = {1'b1, 7'd0, hi[8]};
      default: param_word = {1'b1, hi[7:0]};
    endcase
  endfunction

  // Request qualification straight from the inputs so the window can be latched on the start edge.
`ifdef RECT_CLIP_EN
  localparam logic [8:0] X_MAX = 9'(H_RES - 1);
  localparam logic [8:0] Y_MAX = 9'(V_RES - 1);
  localparam logic [9:0] H_LIM = 10'(H_RES);
  localparam logic [9:0] V_LIM = 10'(V_RES);
`endif

  always_comb begin
`ifdef RECT_CLIP_EN
    x1_eff    = (x1 > X_MAX) ? X_MAX : x1;
    y1_eff    = (y1 > Y_MAX) ? Y_MAX : y1;
    off_panel = ({1'b0, x0} >= H_LIM) || ({1'b0, y0} >= V_LIM);
`else
    x1_eff    = x1;
    y1_eff    = y1;
    off_panel = 1'b0;
`endif
    req_bad  = off_panel || (x0 > x1_eff) || (y0 > y1_eff);
    w_pix    = {1'b0, x1_eff} - {1'b0, x0} + 10'd1;
    h_pix    = {1'b0, y1_eff} - {1'b0, y0} + 10'd1;
    area     = {10'd0, w_pix} * {10'd0, h_pix};
    // Index of the final pixel; comparing against N-1 avoids a wider counter.
    n_last_d = 17'(area - 20'd1);
  end

  assign accept = (state == IDLE) && start && !req_bad;
  assign adv    = en_write && wr_done;

  always_comb begin
    state_nxt   = state;
    pidx_nxt    = pidx;
    pix_cnt_nxt = pix_cnt;
    en_nxt      = en_write;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    data_nxt    = data;

    case (state)
      IDLE: begin
        if (start) begin
          if (req_bad) begin
            err_nxt = 1'b1;
          end else begin
            state_nxt   = CASET;
            pidx_nxt    = 2'd0;
            pix_cnt_nxt = 17'd0;
            en_nxt      = 1'b1;
            busy_nxt    = 1'b1;
          end
        end
      end
      CASET:  if (adv) begin state_nxt = XPARAM; pidx_nxt = 2'd0; end
      XPARAM: if (adv) begin
                if (pidx == 2'd3) state_nxt = RASET;
                else              pidx_nxt  = pidx + 2'd1;
              end
      RASET:  if (adv) begin state_nxt = YPARAM; pidx_nxt = 2'd0; end
      YPARAM: if (adv) begin
                if (pidx == 2'd3) state_nxt = RAMWR;
                else              pidx_nxt  = pidx + 2'd1;
              end
      RAMWR:  if (adv) state_nxt = PIX_HI;
      PIX_HI: if (adv) state_nxt = PIX_LO;
      PIX_LO: if (adv) begin
                if (pix_cnt == n_last) begin
                  state_nxt = FINISH;
                  en_nxt    = 1'b0;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
                end else begin
                  state_nxt   = PIX_HI;
                  pix_cnt_nxt = pix_cnt + 17'd1;
                end
              end
      // One-cycle tail so a start coincident with done is not taken.
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Word for the state being entered; unchanged while stalled, so data only moves after wr_done.
    case (state_nxt)
      CASET:   data_nxt = CMD_CASET;
      XPARAM:  data_nxt = param_word(x0_q, x1_q, pidx_nxt);
      RASET:   data_nxt = CMD_RASET;
      YPARAM:  data_nxt = param_word(y0_q, y1_q, pidx_nxt);
      RAMWR:   data_nxt = CMD_RAMWR;
      PIX_HI:  data_nxt = {1'b1, color_q[15:8]};
      PIX_LO:  data_nxt = {1'b1, color_q[7:0]};
      default: data_nxt = data;
    endcase
  end

  always_ff @(posedge sys_clk_50MHz or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= IDLE;
      pidx     <= 2'd0;
      pix_cnt  <= 17'd0;
      n_last   <= 17'd0;
      x0_q     <= 9'd0;
      x1_q     <= 9'd0;
      y0_q     <= 9'd0;
      y1_q     <= 9'd0;
      color_q  <= 16'd0;
      data     <= 9'h000;
      en_write <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      pidx     <= pidx_nxt;
      pix_cnt  <= pix_cnt_nxt;
      data     <= data_nxt;
      en_write <= en_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      if (accept) begin
        x0_q    <= x0;
        x1_q    <= x1_eff;
        y0_q    <= y0;
        y1_q    <= y1_eff;
        color_q <= color;
        n_last  <= n_last_d;
      end
    end
  end

endmodule
